imem_loader: RTL and testbench

Program loader on the write side of the byte-cell instruction memory. It accepts a byte stream over a valid/ready handshake, parses a length header, and writes each payload byte into consecutive instruction-memory cells. The byte order matches the big-endian 4-byte fetch, so byte k of the stream lands at cell k. It holds the core in reset until a load completes cleanly, and sits between the boot/debug byte source and the instruction memory write port.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and memory cell write port of the program loader
interface imem_loader_if #(
    parameter int MEM_CELL_SIZE = 8,
    parameter int AW            = 6
);
    logic [MEM_CELL_SIZE-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [MEM_CELL_SIZE-1:0] wr_data;

    // master: boot/debug byte source and memory; slave: the loader
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte stream loader for the instruction memory
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int WORD_LEN      = 32,
    parameter int MEM_CELL_SIZE = 8,
    parameter int INST_MEM_SIZE = 64,
    parameter int AW            = $clog2(INST_MEM_SIZE)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    imem_loader_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_rstn,
    output logic [15:0] bytes_written
);
    localparam logic [15:0] MAX_LEN  = 16'(INST_MEM_SIZE);
    localparam logic [15:0] WORD_MSK = 16'(WORD_LEN / MEM_CELL_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_PAYLOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state;
    logic                     active;
    logic [MEM_CELL_SIZE-1:0] len_hi;
    logic [15:0]              length;
    logic [15:0]              count;
    logic [15:0]              hdr_len;

    assign hdr_len      = 16'({len_hi, bus.in_data});
    assign bus.in_ready = active;
    assign busy         = active;
    assign bytes_written = count;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [MEM_CELL_SIZE-1:0] sum;
    logic [MEM_CELL_SIZE-1:0] sum_next;
    assign sum_next = sum + bus.in_data;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            active      <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_rstn    <= 1'b0;
            len_hi      <= '0;
            length      <= '0;
            count       <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_HDR_HI;
                        active   <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_rstn <= 1'b0;
                        count    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum      <= '0;
`endif
                    end
                end
                S_HDR_HI: begin
                    if (bus.in_valid) begin
                        len_hi <= bus.in_data;
                        state  <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (bus.in_valid) begin
                        length <= hdr_len;
                        // Rejecting oversize lengths here is what makes wr_addr wrap impossible.
                        if (hdr_len > MAX_LEN || (hdr_len & WORD_MSK) != 16'd0) begin
                            state  <= S_ERROR;
                            active <= 1'b0;
                            error  <= 1'b1;
                        end else if (hdr_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= S_CHECK;
`else
                            state    <= S_DONE;
                            active   <= 1'b0;
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
`endif
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (bus.in_valid) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= count[AW-1:0];
                        bus.wr_data <= bus.in_data;
                        count       <= count + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum         <= sum_next;
`endif
                        if (count == length - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= S_CHECK;
`else
                            state    <= S_DONE;
                            active   <= 1'b0;
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (bus.in_valid) begin
                        active <= 1'b0;
                        // Payload plus checksum byte must sum to zero mod 256.
                        if (sum_next == '0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        busy, done, error, cpu_rstn;
    logic [15:0] bytes_written;
    int          tests_run = 0;
    int          tests_failed = 0;

    logic [7:0]  mem [0:63];
    logic [5:0]  addr_log [0:255];
    int          wr_cnt = 0;
    logic [7:0]  pl [0:7] = '{8'h80, 8'hA0, 8'h00, 8'h07, 8'h04, 8'h01, 8'h18, 8'h00};

    always #5 clk = ~clk;

    imem_loader_if #(.MEM_CELL_SIZE(8), .AW(6)) bus ();

    imem_loader dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .bus(bus.slave),
        .busy(busy),
        .done(done),
        .error(error),
        .cpu_rstn(cpu_rstn),
        .bytes_written(bytes_written)
    );

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            mem[bus.wr_addr] = bus.wr_data;
            if (wr_cnt < 256) addr_log[wr_cnt] = bus.wr_addr;
            wr_cnt++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL send_timeout: in_ready=%b want 1 for byte %h", bus.in_ready, b);
        end
        tick();
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b1; idle();
        tick();
        tests_run++; if ({bus.in_ready, bus.wr_en, busy, done, error, cpu_rstn} !== 6'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 000000", {bus.in_ready, bus.wr_en, busy, done, error, cpu_rstn}); end
        tests_run++; if ({bus.wr_addr, bus.wr_data, bytes_written} !== 30'b0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", {bus.wr_addr, bus.wr_data, bytes_written}); end
        rstn = 1'b1; start = 1'b0;
        tick();
        tests_run++; if ({busy, cpu_rstn} !== 2'b00) begin tests_failed++; $display("FAIL reset_idle: busy,cpu_rstn=%b want 00", {busy, cpu_rstn}); end
    endtask

    task automatic test_basic_load;
        int base;
        pulse_start();
        tests_run++; if ({busy, bus.in_ready} !== 2'b11) begin tests_failed++; $display("FAIL basic_busy: got %b want 11", {busy, bus.in_ready}); end
        base = wr_cnt;
        send(8'h00); send(8'h08);
        for (int i = 0; i < 8; i++) send(pl[i]);
        tests_run++; if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 6'd7, 8'h00}) begin tests_failed++; $display("FAIL basic_last_write: got %b/%0d/%h want 1/7/00", bus.wr_en, bus.wr_addr, bus.wr_data); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_early_done: got %b want 0", done); end
        send(8'hBC);
`endif
        tests_run++; if ({done, cpu_rstn, error, bus.in_ready} !== 4'b1100) begin tests_failed++; $display("FAIL basic_done: done,cpu_rstn,error,ready=%b want 1100", {done, cpu_rstn, error, bus.in_ready}); end
        tests_run++; if (bytes_written !== 16'd8) begin tests_failed++; $display("FAIL basic_bytes: got %0d want 8", bytes_written); end
        idle(); tick();
        tests_run++; if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL basic_wr_idle: got %b want 0", bus.wr_en); end
        tests_run++; if (wr_cnt - base !== 8) begin tests_failed++; $display("FAIL basic_wr_count: got %0d want 8", wr_cnt - base); end
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (mem[i] !== pl[i] || addr_log[base + i] !== 6'(i)) begin tests_failed++; $display("FAIL basic_cell%0d: data %h addr %0d want %h/%0d", i, mem[i], addr_log[base + i], pl[i], i); end
        end
    endtask

    task automatic test_bad_length(input logic [7:0] lo, input string name);
        int base;
        pulse_start();
        tests_run++; if ({done, error, cpu_rstn, bytes_written} !== 19'b0) begin tests_failed++; $display("FAIL %s_clear: done,error,cpu_rstn=%b bytes=%0d want 000/0", name, {done, error, cpu_rstn}, bytes_written); end
        base = wr_cnt;
        send(8'h00); send(lo);
        tests_run++; if ({error, done, cpu_rstn, busy, bus.wr_en} !== 5'b10000) begin tests_failed++; $display("FAIL %s_error: error,done,cpu_rstn,busy,wr_en=%b want 10000", name, {error, done, cpu_rstn, busy, bus.wr_en}); end
        idle(); tick(); tick();
        tests_run++; if (wr_cnt - base !== 0 || error !== 1'b1) begin tests_failed++; $display("FAIL %s_nowrite: writes %0d error %b want 0/1", name, wr_cnt - base, error); end
    endtask

    task automatic test_toggle_valid;
        pulse_start();
        send(8'h00); send(8'h08);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'h10 + 8'(i);
            tick();
            tests_run++; if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 6'(i), 8'h10 + 8'(i)}) begin tests_failed++; $display("FAIL toggle_write%0d: got %b/%0d/%h want 1/%0d/%h", i, bus.wr_en, bus.wr_addr, bus.wr_data, i, 8'h10 + 8'(i)); end
            bus.in_valid = 1'b0;
            tick();
            tests_run++; if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL toggle_gap%0d: wr_en %b want 0", i, bus.wr_en); end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h64);
        idle();
`endif
        tests_run++; if ({done, bytes_written} !== {1'b1, 16'd8}) begin tests_failed++; $display("FAIL toggle_done: done %b bytes %0d want 1/8", done, bytes_written); end
    endtask

    task automatic test_reset_midload;
        int base;
        pulse_start();
        send(8'h00); send(8'h08);
        send(8'h55); send(8'h66); send(8'h77);
        rstn = 1'b0; idle();
        tick();
        tests_run++; if ({bus.in_ready, bus.wr_en, busy, done, error, cpu_rstn, bus.wr_addr, bus.wr_data, bytes_written} !== 36'b0) begin tests_failed++; $display("FAIL midrst_outputs: got %h want 0", {bus.in_ready, bus.wr_en, busy, done, error, cpu_rstn, bus.wr_addr, bus.wr_data, bytes_written}); end
        rstn = 1'b1;
        base = wr_cnt;
        tick(); tick();
        tests_run++; if (wr_cnt - base !== 0) begin tests_failed++; $display("FAIL midrst_nowrite: got %0d writes want 0", wr_cnt - base); end
        pulse_start();
        send(8'h00); send(8'h08);
        for (int i = 0; i < 8; i++) send(8'hC0 + 8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hE4);
`endif
        idle(); tick();
        tests_run++; if ({done, cpu_rstn} !== 2'b11 || wr_cnt - base !== 8 || addr_log[base] !== 6'd0) begin tests_failed++; $display("FAIL midrst_reload: done,cpu_rstn=%b writes %0d first addr %0d want 11/8/0", {done, cpu_rstn}, wr_cnt - base, addr_log[base]); end
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (mem[i] !== 8'hC0 + 8'(i)) begin tests_failed++; $display("FAIL midrst_cell%0d: got %h want %h", i, mem[i], 8'hC0 + 8'(i)); end
        end
    endtask

    task automatic test_zero_length;
        int base;
        pulse_start();
        base = wr_cnt;
        send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tests_run++; if ({done, busy} !== 2'b01) begin tests_failed++; $display("FAIL zero_wait_ck: done,busy=%b want 01", {done, busy}); end
        send(8'h00);
`endif
        tests_run++; if ({done, cpu_rstn, error, bus.wr_en} !== 4'b1100 || bytes_written !== 16'd0) begin tests_failed++; $display("FAIL zero_done: done,cpu_rstn,error,wr_en=%b bytes %0d want 1100/0", {done, cpu_rstn, error, bus.wr_en}, bytes_written); end
        idle(); tick();
        tests_run++; if (wr_cnt - base !== 0) begin tests_failed++; $display("FAIL zero_nowrite: got %0d writes want 0", wr_cnt - base); end
    endtask

    task automatic test_start_ignored;
        pulse_start();
        send(8'h00);
        idle();
        pulse_start();
        send(8'h04);
        tests_run++; if (bus.wr_en !== 1'b0) begin tests_failed++; $display("FAIL busy_start_hdr: wr_en %b want 0", bus.wr_en); end
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h56);
`endif
        idle();
        tests_run++; if ({done, bytes_written} !== {1'b1, 16'd4}) begin tests_failed++; $display("FAIL busy_start_done: done %b bytes %0d want 1/4", done, bytes_written); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        pulse_start();
        send(8'h00); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL ck_wait: done %b want 0", done); end
        send(8'hF6);
        tests_run++; if ({done, error, cpu_rstn} !== 3'b101) begin tests_failed++; $display("FAIL ck_good: done,error,cpu_rstn=%b want 101", {done, error, cpu_rstn}); end
        pulse_start();
        send(8'h00); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hFF);
        tests_run++; if ({done, error, cpu_rstn} !== 3'b010) begin tests_failed++; $display("FAIL ck_bad: done,error,cpu_rstn=%b want 010", {done, error, cpu_rstn}); end
        idle();
    endtask
`endif

    initial begin
        rstn = 1'b0; start = 1'b0; idle();
        test_reset();
        test_basic_load();
        test_bad_length(8'h06, "len6");
        test_bad_length(8'h44, "len68");
        test_toggle_valid();
        test_reset_midload();
        test_zero_length();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
